// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag fields, line geometry and responder states.
package sysbus_pkg;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [3:0] TYPE_MEMORY = 4'h0;
    localparam logic [3:0] TYPE_MMIO   = 4'h1;

    typedef struct packed {
        logic       rw;
        logic [3:0] typ;
        logic [7:0] id;
    } tag_t;

    localparam int unsigned LINE_BEATS = 8;
    localparam int unsigned LINE_BYTES = 64;

    // Uncached window [640 KiB, 1 MiB)
    localparam logic [63:0] MMIO_LO = 64'h0000_0000_000A_0000;
    localparam logic [63:0] MMIO_HI = 64'h0000_0000_0010_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WAIT,
        ST_RESP
    } resp_state_e;

    function automatic logic is_last_beat(input logic [2:0] beat);
        return beat == 3'(LINE_BEATS - 1);
    endfunction

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response channel between the core initiator and a memory responder.
interface sysbus_mem_responder_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_WIDTH  = 13
) ();
    logic                  reqcyc;
    logic [DATA_WIDTH-1:0] req;
    logic [TAG_WIDTH-1:0]  reqtag;
    logic                  reqack;
    logic                  respcyc;
    logic [DATA_WIDTH-1:0] resp;
    logic [TAG_WIDTH-1:0]  resptag;
    logic                  respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_mem_array.sv
// Single-port backing store: synchronous write, combinational read on the same index.
module sysbus_mem_array #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_WORDS  = 4096
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    output logic [DATA_WIDTH-1:0]        rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder: one line request at a time, eight beats per line.
// Define SYSBUS_RESP_MMIO_EN to treat MMIO-typed or 640K..1M requests as uncached.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned TAG_WIDTH    = 13,
    parameter int unsigned MEM_WORDS    = 4096,
    parameter int unsigned RESP_LATENCY = 4
) (
    input logic                   clk,
    input logic                   reset,
    sysbus_mem_responder_if.slave bus
);
    localparam int unsigned AW  = $clog2(MEM_WORDS);
    localparam int unsigned LW  = AW - 3;
    localparam logic [3:0]  LAT = 4'(RESP_LATENCY);

    resp_state_e           state_q, state_d;
    logic [LW-1:0]         line_q, line_d;
    logic [2:0]            beat_q, beat_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  ack_q, ack_d;
    logic                  uncached_q, uncached_d;

    logic                  req_uncached;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

`ifdef SYSBUS_RESP_MMIO_EN
    tag_t req_tag;
    assign req_tag      = tag_t'(bus.reqtag);
    assign req_uncached = (req_tag.typ == TYPE_MMIO)
                       || ((bus.req >= DATA_WIDTH'(MMIO_LO)) && (bus.req < DATA_WIDTH'(MMIO_HI)));
`else
    assign req_uncached = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            line_q     <= '0;
            beat_q     <= '0;
            cnt_q      <= '0;
            tag_q      <= '0;
            ack_q      <= 1'b0;
            uncached_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            ack_q      <= ack_d;
            uncached_q <= uncached_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        tag_d      = tag_q;
        ack_d      = 1'b0;
        uncached_d = uncached_q;
        unique case (state_q)
            ST_IDLE: if (bus.reqcyc) begin
                line_d     = bus.req[6 +: LW];
                tag_d      = bus.reqtag;
                ack_d      = 1'b1;
                beat_d     = '0;
                cnt_d      = LAT;
                uncached_d = req_uncached;
                state_d    = (bus.reqtag[TAG_WIDTH-1] == RW_WRITE) ? ST_WDATA : ST_WAIT;
            end
            ST_WDATA: if (bus.reqcyc) begin
                beat_d = beat_q + 3'd1;
                if (is_last_beat(beat_q)) state_d = ST_IDLE;
            end
            // Leaving at count 1 puts the first beat RESP_LATENCY cycles after reqack.
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    beat_d  = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: if (bus.respack) begin
                beat_d = beat_q + 3'd1;
                if (is_last_beat(beat_q)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.reqack  = ack_q;
        bus.respcyc = (state_q == ST_RESP);
        mem_we      = (state_q == ST_WDATA) && bus.reqcyc && !uncached_q;
        bus.resp    = '0;
        bus.resptag = '0;
        if (state_q == ST_RESP) begin
            bus.resp    = uncached_q ? '1 : mem_rdata;
            bus.resptag = tag_q;
        end
    end

    sysbus_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  ({line_q, beat_q}),
        .wdata_i (bus.req),
        .rdata_o (mem_rdata)
    );
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed self-checking bench for sysbus_mem_responder (honours SYSBUS_RESP_MMIO_EN).
module tb_sysbus_mem_responder;
    import sysbus_pkg::*;

    localparam int unsigned LAT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Per-read options, reset to defaults after each use
    int          abort_at  = -1;
    int          stall_b1  = -1;
    int          stall_b2  = -1;
    int          stall_len = 0;
    bit          hold_en   = 1'b0;
    logic [63:0] hold_addr = '0;
    logic [12:0] hold_tag  = '0;

    sysbus_mem_responder_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) bus ();

    sysbus_mem_responder #(
        .DATA_WIDTH   (64),
        .TAG_WIDTH    (13),
        .MEM_WORDS    (4096),
        .RESP_LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_line(input logic [63:0] addr, input logic [3:0] typ,
                              input logic [63:0] first, input int gap_after);
        bus.req     = addr;
        bus.reqtag  = {RW_WRITE, typ, 8'h5A};
        bus.reqcyc  = 1'b1;
        bus.respack = 1'b0;
        tick();
        check("wr_ack", bus.reqack, 1);
        for (int b = 0; b < 8; b++) begin
            bus.req    = first + 64'(b);
            bus.reqcyc = 1'b1;
            tick();
            if (b == 0) check("wr_ack_one_cycle", bus.reqack, 0);
            check("wr_no_resp", bus.respcyc, 0);
            if (b == gap_after) begin
                bus.reqcyc = 1'b0;
                tick();
            end
        end
        bus.reqcyc = 1'b0;
    endtask

    task automatic read_line(input logic [63:0] addr, input logic [3:0] typ, input logic [7:0] id,
                             input logic [63:0] first, input logic [63:0] inc);
        int          k;
        int          cyc;
        int          stalls;
        bit          aborted;
        logic [12:0] tagv;
        logic [63:0] exp;
        tagv        = {RW_READ, typ, id};
        bus.req     = addr;
        bus.reqtag  = tagv;
        bus.reqcyc  = 1'b1;
        bus.respack = 1'b1;
        tick();
        check("rd_ack", bus.reqack, 1);
        bus.reqcyc = 1'b0;
        k = 1;
        while (bus.respcyc !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("rd_first_beat_cycle", 64'(k), 64'(LAT + 1));
        cyc     = 0;
        stalls  = 0;
        aborted = 1'b0;
        for (int b = 0; b < 8; b++) begin
            exp = first + 64'(b) * inc;
            if (b == abort_at) begin
                reset = 1'b1;
                #1;
                check("rst_respcyc", bus.respcyc, 0);
                check("rst_resp", bus.resp, 0);
                check("rst_resptag", bus.resptag, 0);
                #2;
                reset   = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (b == stall_b1 || b == stall_b2) begin
                bus.respack = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    cyc++;
                    stalls++;
                    check("rd_stall_hold", bus.resp, exp);
                end
                bus.respack = 1'b1;
            end
            check("rd_beat", bus.resp, exp);
            check("rd_tag", bus.resptag, 64'(tagv));
            if (hold_en && b == 0) begin
                bus.req    = hold_addr;
                bus.reqtag = hold_tag;
                bus.reqcyc = 1'b1;
            end
            if (hold_en) check("busy_no_ack", bus.reqack, 0);
            tick();
            cyc++;
        end
        if (!aborted) begin
            check("rd_done", bus.respcyc, 0);
            check("rd_cycles", 64'(cyc), 64'(8 + stalls));
            if (hold_en) check("busy_no_ack_end", bus.reqack, 0);
        end
        abort_at  = -1;
        stall_b1  = -1;
        stall_b2  = -1;
        stall_len = 0;
        hold_en   = 1'b0;
    endtask

    initial begin
        bus.reqcyc  = 1'b0;
        bus.req     = '0;
        bus.reqtag  = '0;
        bus.respack = 1'b0;
        #12;
        check("reset_reqack", bus.reqack, 0);
        check("reset_respcyc", bus.respcyc, 0);
        check("reset_resp", bus.resp, 0);
        check("reset_resptag", bus.resptag, 0);
        #4 reset = 1'b0;
        tick();

        // Preload line 0x40, plain read with offset address
        write_line(64'h40, TYPE_MEMORY, 64'h1000, -1);
        read_line(64'h45, TYPE_MEMORY, 8'h21, 64'h1000, 64'd1);

        // Backpressure on beats 2 and 5
        stall_b1 = 2; stall_b2 = 5; stall_len = 3;
        read_line(64'h45, TYPE_MEMORY, 8'h22, 64'h1000, 64'd1);

        // Write with a gap after beat 3, then read back
        write_line(64'h80, TYPE_MEMORY, 64'hA0, 3);
        read_line(64'h80, TYPE_MEMORY, 8'h23, 64'hA0, 64'd1);

        // Request held during RESP is accepted only after the line completes
        hold_en = 1'b1; hold_addr = 64'h80; hold_tag = {RW_READ, TYPE_MEMORY, 8'h77};
        read_line(64'h40, TYPE_MEMORY, 8'h24, 64'h1000, 64'd1);
        read_line(64'h80, TYPE_MEMORY, 8'h77, 64'hA0, 64'd1);

        // Reset during beat 4, then a full read
        abort_at = 4;
        read_line(64'h40, TYPE_MEMORY, 8'h25, 64'h1000, 64'd1);
        @(negedge clk);
        read_line(64'h40, TYPE_MEMORY, 8'h26, 64'h1000, 64'd1);

        // Address bits above the store wrap: 0x80C0 aliases 0xC0
        write_line(64'h80C0, TYPE_MEMORY, 64'hB0, -1);
        read_line(64'hC0, TYPE_MEMORY, 8'h27, 64'hB0, 64'd1);

        // 0xA0000 aliases line 0x0 in the backing store
        write_line(64'h0, TYPE_MEMORY, 64'hD0, -1);
`ifdef SYSBUS_RESP_MMIO_EN
        read_line(64'hA0000, TYPE_MEMORY, 8'h28, '1, 64'd0);
        write_line(64'hA0000, TYPE_MEMORY, 64'hE0, -1);
        read_line(64'h0, TYPE_MEMORY, 8'h29, 64'hD0, 64'd1);
        read_line(64'h40, TYPE_MMIO, 8'h2A, '1, 64'd0);
        write_line(64'h40, TYPE_MMIO, 64'hF0, -1);
        read_line(64'h40, TYPE_MEMORY, 8'h2B, 64'h1000, 64'd1);
`else
        write_line(64'hA0000, TYPE_MEMORY, 64'hE0, -1);
        read_line(64'h0, TYPE_MEMORY, 8'h29, 64'hE0, 64'd1);
        read_line(64'h40, TYPE_MMIO, 8'h2A, 64'h1000, 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
